// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants, types and helpers for the hazard scoreboard.
// Tnew/Tuse fields are stored as raw bits and compared through $signed.
package hazard_scoreboard_pkg;

  localparam int T_SIZE    = 3;
  localparam int REG_SIZE  = 5;
  localparam int NUM_SLOTS = 3;
  localparam int SLOT_E    = 0;
  localparam int SLOT_M    = 1;
  localparam int SLOT_W    = 2;

  localparam logic [T_SIZE-1:0] TUSE_IGNORE = 3'd3;
  localparam logic [T_SIZE-1:0] TNEW_ZERO   = 3'd0;
  localparam logic [T_SIZE-1:0] TNEW_ONE    = 3'd1;

  typedef enum logic [1:0] {
    FWD_GRF = 2'd0,
    FWD_E   = 2'd1,
    FWD_M   = 2'd2,
    FWD_W   = 2'd3
  } fwd_e;

  typedef enum logic [1:0] {
    STAGE_DECODE    = 2'd0,
    STAGE_EXECUTE   = 2'd1,
    STAGE_MEMORY    = 2'd2,
    STAGE_WRITEBACK = 2'd3
  } stage_e;

  typedef struct packed {
    logic              hit;
    logic [T_SIZE-1:0] tnew;
    fwd_e              code;
  } pick_t;

  // Count one stage closer to the result; never goes below zero.
  function automatic logic [T_SIZE-1:0] sat_dec(input logic [T_SIZE-1:0] t);
    logic [T_SIZE-1:0] r;
    if ($signed(t) > $signed(TNEW_ZERO)) begin
      r = t - TNEW_ONE;
    end else begin
      r = TNEW_ZERO;
    end
    return r;
  endfunction

  // Youngest matching slot wins, even if its value is not ready yet.
  function automatic pick_t pick_slot(input logic [NUM_SLOTS-1:0] hit,
                                      input logic [NUM_SLOTS-1:0][T_SIZE-1:0] tnew);
    pick_t p;
    p.hit  = 1'b0;
    p.tnew = TNEW_ZERO;
    p.code = FWD_GRF;
    if (hit[SLOT_E]) begin
      p.hit  = 1'b1;
      p.tnew = tnew[SLOT_E];
      p.code = FWD_E;
    end else if (hit[SLOT_M]) begin
      p.hit  = 1'b1;
      p.tnew = tnew[SLOT_M];
      p.code = FWD_M;
    end else if (hit[SLOT_W]) begin
      p.hit  = 1'b1;
      p.tnew = tnew[SLOT_W];
      p.code = FWD_W;
    end else begin
      p.hit  = 1'b0;
    end
    return p;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_match.sv
// One operand against one in-flight slot: reports a hit and that slot's Tnew.
module hazard_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int T_W   = T_SIZE,
  parameter int REG_W = REG_SIZE
) (
  input  logic [REG_W-1:0] src,
  input  logic             valid,
  input  logic             wen,
  input  logic [REG_W-1:0] wreg,
  input  logic [T_W-1:0]   tnew_in,
  output logic             hit,
  output logic [T_W-1:0]   tnew
);

  // Register $0 is hard-wired, so it never produces a hit.
  always_comb begin
    hit  = 1'b0;
    tnew = {T_W{1'b0}};
    if (valid && wen && (wreg == src) && (src != {REG_W{1'b0}})) begin
      hit  = 1'b1;
      tnew = tnew_in;
    end else begin
      hit  = 1'b0;
      tnew = {T_W{1'b0}};
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard stall and forwarding selects for D and E operands of the pipeline.
// Define HAZARD_FORWARD_EN for forwarding; otherwise any pending writer stalls the reader.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int T_W   = T_SIZE,
  parameter int REG_W = REG_SIZE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  d_valid,
  input  logic [REG_W-1:0]      d_rs,
  input  logic [REG_W-1:0]      d_rt,
  input  logic signed [T_W-1:0] d_tuse_rs,
  input  logic signed [T_W-1:0] d_tuse_rt,
  input  logic                  d_wen,
  input  logic [REG_W-1:0]      d_wreg,
  input  logic signed [T_W-1:0] d_tnew,
  output logic                  stall,
  output logic [1:0]            fwd_rs_d,
  output logic [1:0]            fwd_rt_d,
  output logic [1:0]            fwd_rs_e,
  output logic [1:0]            fwd_rt_e
);

  logic [NUM_SLOTS-1:0]            valid_r;
  logic [NUM_SLOTS-1:0]            wen_r;
  logic [NUM_SLOTS-1:0][REG_W-1:0] wreg_r;
  logic [NUM_SLOTS-1:0][T_W-1:0]   tnew_r;
  logic [REG_W-1:0]                e_rs_r;
  logic [REG_W-1:0]                e_rt_r;

  logic [NUM_SLOTS-1:0]            rs_d_hit_s, rt_d_hit_s, rs_e_hit_s, rt_e_hit_s;
  logic [NUM_SLOTS-1:0][T_W-1:0]   rs_d_tnew_s, rt_d_tnew_s, rs_e_tnew_s, rt_e_tnew_s;
  pick_t                           rs_d_pick_s, rt_d_pick_s, rs_e_pick_s, rt_e_pick_s;
  logic                            haz_rs_s, haz_rt_s, stall_s;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_d_match
    hazard_match #(.T_W(T_W), .REG_W(REG_W)) u_rs (
      .src(d_rs), .valid(valid_r[i]), .wen(wen_r[i]), .wreg(wreg_r[i]),
      .tnew_in(tnew_r[i]), .hit(rs_d_hit_s[i]), .tnew(rs_d_tnew_s[i])
    );
    hazard_match #(.T_W(T_W), .REG_W(REG_W)) u_rt (
      .src(d_rt), .valid(valid_r[i]), .wen(wen_r[i]), .wreg(wreg_r[i]),
      .tnew_in(tnew_r[i]), .hit(rt_d_hit_s[i]), .tnew(rt_d_tnew_s[i])
    );
  end

  // The E operand can only be fed from older stages M and W.
  for (genvar i = SLOT_M; i < NUM_SLOTS; i++) begin : g_e_match
    hazard_match #(.T_W(T_W), .REG_W(REG_W)) u_rs (
      .src(e_rs_r), .valid(valid_r[i]), .wen(wen_r[i]), .wreg(wreg_r[i]),
      .tnew_in(tnew_r[i]), .hit(rs_e_hit_s[i]), .tnew(rs_e_tnew_s[i])
    );
    hazard_match #(.T_W(T_W), .REG_W(REG_W)) u_rt (
      .src(e_rt_r), .valid(valid_r[i]), .wen(wen_r[i]), .wreg(wreg_r[i]),
      .tnew_in(tnew_r[i]), .hit(rt_e_hit_s[i]), .tnew(rt_e_tnew_s[i])
    );
  end
  assign rs_e_hit_s[SLOT_E]  = 1'b0;
  assign rt_e_hit_s[SLOT_E]  = 1'b0;
  assign rs_e_tnew_s[SLOT_E] = TNEW_ZERO;
  assign rt_e_tnew_s[SLOT_E] = TNEW_ZERO;

  // Resolve the youngest matching writer for every operand.
  always_comb begin
    rs_d_pick_s = pick_slot(rs_d_hit_s, rs_d_tnew_s);
    rt_d_pick_s = pick_slot(rt_d_hit_s, rt_d_tnew_s);
    rs_e_pick_s = pick_slot(rs_e_hit_s, rs_e_tnew_s);
    rt_e_pick_s = pick_slot(rt_e_hit_s, rt_e_tnew_s);
  end

`ifdef HAZARD_FORWARD_EN
  // Stall only when the producer cannot deliver by the time the operand is used.
  always_comb begin
    haz_rs_s = 1'b0;
    haz_rt_s = 1'b0;
    fwd_rs_d = FWD_GRF;
    fwd_rt_d = FWD_GRF;
    fwd_rs_e = FWD_GRF;
    fwd_rt_e = FWD_GRF;
    if (d_valid && (d_tuse_rs != TUSE_IGNORE) && rs_d_pick_s.hit) begin
      haz_rs_s = $signed(rs_d_pick_s.tnew) > $signed(d_tuse_rs);
    end else begin
      haz_rs_s = 1'b0;
    end
    if (d_valid && (d_tuse_rt != TUSE_IGNORE) && rt_d_pick_s.hit) begin
      haz_rt_s = $signed(rt_d_pick_s.tnew) > $signed(d_tuse_rt);
    end else begin
      haz_rt_s = 1'b0;
    end
    if (d_valid && rs_d_pick_s.hit && (rs_d_pick_s.tnew == TNEW_ZERO)) begin
      fwd_rs_d = rs_d_pick_s.code;
    end else begin
      fwd_rs_d = FWD_GRF;
    end
    if (d_valid && rt_d_pick_s.hit && (rt_d_pick_s.tnew == TNEW_ZERO)) begin
      fwd_rt_d = rt_d_pick_s.code;
    end else begin
      fwd_rt_d = FWD_GRF;
    end
    if (rs_e_pick_s.hit && (rs_e_pick_s.tnew == TNEW_ZERO)) begin
      fwd_rs_e = rs_e_pick_s.code;
    end else begin
      fwd_rs_e = FWD_GRF;
    end
    if (rt_e_pick_s.hit && (rt_e_pick_s.tnew == TNEW_ZERO)) begin
      fwd_rt_e = rt_e_pick_s.code;
    end else begin
      fwd_rt_e = FWD_GRF;
    end
  end
`else
  logic unused_s;
  assign unused_s = ^{rs_d_pick_s.tnew, rs_d_pick_s.code, rt_d_pick_s.tnew, rt_d_pick_s.code,
                      rs_e_pick_s, rt_e_pick_s};

  // No bypass anywhere (GRF included), so any pending writer of a used operand stalls.
  always_comb begin
    haz_rs_s = d_valid && (d_tuse_rs != TUSE_IGNORE) && rs_d_pick_s.hit;
    haz_rt_s = d_valid && (d_tuse_rt != TUSE_IGNORE) && rt_d_pick_s.hit;
    fwd_rs_d = FWD_GRF;
    fwd_rt_d = FWD_GRF;
    fwd_rs_e = FWD_GRF;
    fwd_rt_e = FWD_GRF;
  end
`endif

  assign stall_s = haz_rs_s | haz_rt_s;
  assign stall   = stall_s;

  // Advance in-flight writers; a stalled or empty D injects a bubble into E.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= {NUM_SLOTS{1'b0}};
      wen_r   <= {NUM_SLOTS{1'b0}};
      wreg_r  <= {(NUM_SLOTS*REG_W){1'b0}};
      tnew_r  <= {(NUM_SLOTS*T_W){1'b0}};
      e_rs_r  <= {REG_W{1'b0}};
      e_rt_r  <= {REG_W{1'b0}};
    end else begin
      valid_r[SLOT_W] <= valid_r[SLOT_M];
      wen_r[SLOT_W]   <= wen_r[SLOT_M];
      wreg_r[SLOT_W]  <= wreg_r[SLOT_M];
      tnew_r[SLOT_W]  <= sat_dec(tnew_r[SLOT_M]);
      valid_r[SLOT_M] <= valid_r[SLOT_E];
      wen_r[SLOT_M]   <= wen_r[SLOT_E];
      wreg_r[SLOT_M]  <= wreg_r[SLOT_E];
      tnew_r[SLOT_M]  <= sat_dec(tnew_r[SLOT_E]);
      if (!stall_s && d_valid) begin
        valid_r[SLOT_E] <= 1'b1;
        wen_r[SLOT_E]   <= d_wen && (d_wreg != {REG_W{1'b0}});
        wreg_r[SLOT_E]  <= d_wreg;
        tnew_r[SLOT_E]  <= sat_dec(d_tnew);
        e_rs_r          <= d_rs;
        e_rt_r          <= d_rt;
      end else begin
        valid_r[SLOT_E] <= 1'b0;
        wen_r[SLOT_E]   <= 1'b0;
        wreg_r[SLOT_E]  <= {REG_W{1'b0}};
        tnew_r[SLOT_E]  <= TNEW_ZERO;
        e_rs_r          <= {REG_W{1'b0}};
        e_rt_r          <= {REG_W{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed cycle vectors for hazard_scoreboard; expected outputs queued per cycle and checked by a monitor.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic              clk;
  logic              reset;
  logic              d_valid;
  logic [4:0]        d_rs, d_rt, d_wreg;
  logic signed [2:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic              d_wen;
  logic              stall;
  logic [1:0]        fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  typedef struct {
    int         id;
    logic [8:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;
  localparam int IG = 3;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_wen(d_wen), .d_wreg(d_wreg),
    .d_tnew(d_tnew), .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] ex(input int s, input int rsd, input int rtd,
                                     input int rse, input int rte);
    logic [8:0] r;
    r = {s[0], rsd[1:0], rtd[1:0], rse[1:0], rte[1:0]};
    return r;
  endfunction

  task automatic step(input int v, input int rs, input int rt, input int tu_rs, input int tu_rt,
                      input int w, input int wr, input int tn, input int rst, input logic [8:0] e);
    exp_t it;
    @(posedge clk);
    #1;
    d_valid   = (v != 0);
    d_rs      = rs[4:0];
    d_rt      = rt[4:0];
    d_tuse_rs = tu_rs[2:0];
    d_tuse_rt = tu_rt[2:0];
    d_wen     = (w != 0);
    d_wreg    = wr[4:0];
    d_tnew    = tn[2:0];
    reset     = (rst != 0);
    step_id++;
    it.id  = step_id;
    it.exp = e;
    q.push_back(it);
  endtask

  task automatic bub(input logic [8:0] e);
    step(0, 0, 0, IG, IG, 0, 0, 0, 0, e);
  endtask

  // Monitor: the DUT presents a fresh result every cycle; compare on the falling edge.
  initial begin
    exp_t it;
    logic [8:0] got;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        it  = q.pop_front();
        got = {stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e};
        checks++;
        if (got !== it.exp) begin
          errors++;
          $display("FAIL step%0d: got stall=%0b fwd_d=%0d/%0d fwd_e=%0d/%0d, want stall=%0b fwd_d=%0d/%0d fwd_e=%0d/%0d",
                   it.id, got[8], got[7:6], got[5:4], got[3:2], got[1:0],
                   it.exp[8], it.exp[7:6], it.exp[5:4], it.exp[3:2], it.exp[1:0]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; d_valid = 1'b0; d_rs = 5'd0; d_rt = 5'd0; d_wen = 1'b0; d_wreg = 5'd0;
    d_tuse_rs = 3'd3; d_tuse_rt = 3'd3; d_tnew = 3'd0;
    repeat (2) @(posedge clk);
    bub(ex(0, 0, 0, 0, 0));
`ifdef HAZARD_FORWARD_EN
    step(1, 0, 0, 1, 1, 1, 1, 2, 0, ex(0, 0, 0, 0, 0));   // add $1
    step(1, 1, 1, 1, 1, 1, 2, 2, 0, ex(0, 0, 0, 0, 0));   // sub $2,$1,$1
    bub(ex(0, 0, 0, 2, 2));
    bub(ex(0, 0, 0, 0, 0));
    bub(ex(0, 0, 0, 0, 0));
    step(1, 0, 0, 1, IG, 1, 3, 3, 0, ex(0, 0, 0, 0, 0));  // lw $3
    step(1, 3, 0, 0, 0, 0, 0, 0, 0, ex(1, 0, 0, 0, 0));   // beq $3,$0
    step(1, 3, 0, 0, 0, 0, 0, 0, 0, ex(1, 0, 0, 0, 0));
    step(1, 3, 0, 0, 0, 0, 0, 0, 0, ex(0, 3, 0, 0, 0));
    bub(ex(0, 0, 0, 0, 0));
    bub(ex(0, 0, 0, 0, 0));
    step(1, 0, 0, IG, IG, 1, 4, 1, 0, ex(0, 0, 0, 0, 0)); // lui $4
    step(1, 4, 0, 0, IG, 0, 0, 0, 0, ex(0, 1, 0, 0, 0));  // jr $4
    bub(ex(0, 0, 0, 2, 0));
    bub(ex(0, 0, 0, 0, 0));
    step(1, 0, 0, 1, IG, 1, 5, 2, 0, ex(0, 0, 0, 0, 0));  // ori $5
    step(1, 0, 0, IG, IG, 1, 5, 1, 0, ex(0, 0, 0, 0, 0)); // lui $5
    step(1, 5, 0, 0, IG, 0, 0, 0, 0, ex(0, 1, 0, 0, 0));  // jr $5: E beats M
    bub(ex(0, 0, 0, 2, 0));
    bub(ex(0, 0, 0, 0, 0));
    step(1, 0, 0, 1, 1, 1, 7, 2, 0, ex(0, 0, 0, 0, 0));   // add $7
    step(1, 0, 0, IG, IG, 0, 0, 0, 0, ex(0, 0, 0, 0, 0)); // nop
    step(1, 7, 0, 1, 1, 1, 8, 2, 0, ex(0, 2, 0, 0, 0));   // sub $8,$7,$0
    bub(ex(0, 0, 0, 3, 0));
    bub(ex(0, 0, 0, 0, 0));
    step(1, 0, 0, 1, 1, 1, 0, 2, 0, ex(0, 0, 0, 0, 0));   // add $0
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0));   // beq $0,$0
    bub(ex(0, 0, 0, 0, 0));
    step(1, 0, 0, IG, IG, 0, 9, 2, 0, ex(0, 0, 0, 0, 0)); // wen=0 with wreg $9
    step(1, 9, 0, 0, IG, 0, 0, 0, 0, ex(0, 0, 0, 0, 0));
    bub(ex(0, 0, 0, 0, 0));
    step(1, 0, 0, 1, IG, 1, 3, 3, 0, ex(0, 0, 0, 0, 0));  // lw $3
    step(1, 3, 0, 0, 0, 0, 0, 0, 0, ex(1, 0, 0, 0, 0));
    step(1, 3, 0, 0, 0, 0, 0, 0, 1, ex(1, 0, 0, 0, 0));   // reset mid-stall
    step(1, 3, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0));
    bub(ex(0, 0, 0, 0, 0));
    step(1, 0, 0, 1, IG, 1, 3, 3, 0, ex(0, 0, 0, 0, 0));  // lw $3
    step(1, 0, 3, 1, 1, 1, 10, 2, 0, ex(1, 0, 0, 0, 0));  // sub $10,$0,$3
    step(1, 0, 3, 1, 1, 1, 10, 2, 0, ex(0, 0, 0, 0, 0));
    bub(ex(0, 0, 0, 0, 3));
    bub(ex(0, 0, 0, 0, 0));
`else
    step(1, 0, 0, 1, 1, 1, 1, 2, 0, ex(0, 0, 0, 0, 0));   // add $1
    step(1, 1, 1, 1, 1, 1, 6, 2, 0, ex(1, 0, 0, 0, 0));   // or $6,$1,$1
    step(1, 1, 1, 1, 1, 1, 6, 2, 0, ex(1, 0, 0, 0, 0));
    step(1, 1, 1, 1, 1, 1, 6, 2, 0, ex(1, 0, 0, 0, 0));
    step(1, 1, 1, 1, 1, 1, 6, 2, 0, ex(0, 0, 0, 0, 0));
    bub(ex(0, 0, 0, 0, 0));
    bub(ex(0, 0, 0, 0, 0));
    step(1, 0, 0, 1, 1, 1, 0, 2, 0, ex(0, 0, 0, 0, 0));   // add $0
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0));   // beq $0,$0
    bub(ex(0, 0, 0, 0, 0));
    step(1, 0, 0, IG, IG, 0, 9, 2, 0, ex(0, 0, 0, 0, 0)); // wen=0 with wreg $9
    step(1, 9, 0, 0, IG, 0, 0, 0, 0, ex(0, 0, 0, 0, 0));
    step(1, 0, 0, IG, IG, 1, 4, 1, 0, ex(0, 0, 0, 0, 0)); // lui $4
    step(1, 4, 4, IG, IG, 0, 0, 0, 0, ex(0, 0, 0, 0, 0)); // names $4 but uses neither
    step(1, 4, 0, 0, IG, 0, 0, 0, 0, ex(1, 0, 0, 0, 0));  // jr $4
    step(1, 4, 0, 0, IG, 0, 0, 0, 0, ex(1, 0, 0, 0, 0));
    step(1, 4, 0, 0, IG, 0, 0, 0, 0, ex(0, 0, 0, 0, 0));
    bub(ex(0, 0, 0, 0, 0));
    step(1, 0, 0, 1, IG, 1, 3, 3, 0, ex(0, 0, 0, 0, 0));  // lw $3
    step(1, 3, 0, 0, 0, 0, 0, 0, 0, ex(1, 0, 0, 0, 0));
    step(1, 3, 0, 0, 0, 0, 0, 0, 1, ex(1, 0, 0, 0, 0));   // reset mid-stall
    step(1, 3, 0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0));
    bub(ex(0, 0, 0, 0, 0));
`endif
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected results never checked, want 0", q.size());
    end
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
